acc_trua_stage: RTL and testbench

- Sequential accumulation stage directly downstream of the truncated approximate adder in the systolic PE datapath.
- Consumes a stream of signed products and sums cfg_len terms into a register using truncated addition, with the low IGNORE_BIT bits dropped.
- Presents the final sum to the next stage over a valid/ready handshake.
- The adder may be instantiated internally, with operands ACC_W and ACC_W and carry-in 0.

---
 rtl/acc_trua_stage.sv | 153 +++++++++++++++
 tb/tb_acc_trua_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_trua_stage.sv
// acc_trua_stage: accumulates cfg_len signed products with a truncated adder (low IGNORE_BIT
// bits dropped) and offers the sum over valid/ready. Define ACC_SAT_EN to saturate on overflow.
module acc_trua_stage #(
   parameter int DATA_W     = 8,
   parameter int ACC_W      = 16,
   parameter int IGNORE_BIT = 2,
   parameter int LEN_W      = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [LEN_W-1:0]         cfg_len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_data,
   output logic                     ovf
);
   localparam int FW = ACC_W - IGNORE_BIT;
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

   state_e                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [LEN_W-1:0]          cnt_q, cnt_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic                      ovf_q, ovf_d;
   logic signed [ACC_W-1:0]   out_data_q, out_data_d;

   logic signed [ACC_W-1:0]   acc_base;
   logic signed [ACC_W-1:0]   ext;
   logic [ACC_W:0]            add_res;
   logic                      sum_ovf;
   logic signed [ACC_W-1:0]   sum_val;
   logic                      beat;
   logic [LEN_W-1:0]          eff_len;

   // Returns {overflow, sum}; only the upper FW bits take part in the add.
   function automatic logic [ACC_W:0] trunc_add(input logic signed [ACC_W-1:0] x,
                                                input logic signed [ACC_W-1:0] y);
      logic [FW-1:0]    xf, yf, sf;
      logic [ACC_W-1:0] s;
      xf = FW'(x >>> IGNORE_BIT);
      yf = FW'(y >>> IGNORE_BIT);
      sf = xf + yf;
      s  = ACC_W'(sf) << IGNORE_BIT;
      return {(xf[FW-1] == yf[FW-1]) && (sf[FW-1] != xf[FW-1]), s};
   endfunction

`ifdef ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // On overflow both operands share a sign, so the accumulator sign picks the rail.
   function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] s,
                                                        input logic o,
                                                        input logic neg);
      if (!o) return s;
      return neg ? ACC_MIN : ACC_MAX;
   endfunction
`endif

   assign in_ready  = (state_q != HOLD);
   assign out_valid = (state_q == HOLD);
   assign out_data  = out_data_q;
   assign ovf       = ovf_q;

   always_comb begin
      acc_base = (state_q == IDLE) ? '0 : acc_q;
      ext      = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
      add_res  = trunc_add(acc_base, ext);
      sum_ovf  = add_res[ACC_W];
`ifdef ACC_SAT_EN
      sum_val  = saturate(add_res[ACC_W-1:0], sum_ovf, acc_base[ACC_W-1]);
`else
      sum_val  = add_res[ACC_W-1:0];
`endif
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      ovf_d      = ovf_q;
      out_data_d = out_data_q;
      beat       = in_valid && in_ready;
      eff_len    = (cfg_len == '0) ? LEN_ONE : cfg_len;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (beat) begin
                  acc_d = sum_val;
                  cnt_d = LEN_ONE;
                  ovf_d = 1'b0;
                  len_d = eff_len;
                  if (eff_len == LEN_ONE) begin
                     state_d    = HOLD;
                     out_data_d = sum_val;
                  end else begin
                     state_d = ACC;
                  end
               end
            end
            ACC: begin
               if (beat) begin
                  acc_d = sum_val;
                  cnt_d = cnt_q + LEN_ONE;
                  ovf_d = ovf_q | sum_ovf;
                  if (cnt_q + LEN_ONE == len_q) begin
                     state_d    = HOLD;
                     out_data_d = sum_val;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         len_q      <= '0;
         ovf_q      <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         ovf_q      <= ovf_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_acc_trua_stage.sv
// tb_acc_trua_stage: drives two instances (ACC_W=16 and ACC_W=10) with the same stimulus and
// checks them against directed vectors and an arithmetic reference model.
module tb_acc_trua_stage;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [7:0]        cfg_len = 8'd0;
   logic signed [7:0] in_data = 8'sd0;
   logic              in_ready0, out_valid0, ovf0;
   logic              in_ready1, out_valid1, ovf1;
   logic signed [15:0] out_data0;
   logic signed [9:0]  out_data1;

   int total = 0;
   int bad   = 0;
   int beats[8];

   always #5 clk = ~clk;

   acc_trua_stage u0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .ovf(ovf0)
   );

   acc_trua_stage #(.ACC_W(10)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .ovf(ovf1)
   );

   typedef struct packed {
      logic [7:0]        len;
      logic [3:0]        n;
      logic [4:0][7:0]   b;
      logic signed [31:0] d0;
      logic              o0;
      logic signed [31:0] d1;
      logic              o1;
   } vec_t;

   vec_t tbl[7];

   function automatic vec_t mk(input int len, input int n, input int x0, input int x1,
                               input int x2, input int x3, input int x4,
                               input int d0, input int o0, input int d1, input int o1);
      vec_t v;
      v.len  = 8'(len);
      v.n    = 4'(n);
      v.b[0] = 8'(x0);
      v.b[1] = 8'(x1);
      v.b[2] = 8'(x2);
      v.b[3] = 8'(x3);
      v.b[4] = 8'(x4);
      v.d0   = d0;
      v.o0   = o0[0];
      v.d1   = d1;
      v.o1   = o1[0];
      return v;
   endfunction

   // Reference: work on the value scaled down by 2^K, detect range overflow on the exact sum.
   function automatic void model(input int accw, input int n, output int res, output int ov);
      int k;
      int fw;
      int a;
      int s;
      int lo;
      int hi;
      k  = 2;
      fw = accw - k;
      a  = 0;
      ov = 0;
      lo = -(1 << (fw - 1));
      hi = (1 << (fw - 1)) - 1;
      for (int i = 0; i < n; i++) begin
         s = (a >>> k) + (beats[i] >>> k);
         if (s > hi || s < lo) begin
            ov = 1;
`ifdef ACC_SAT_EN
            a = (s > hi) ? ((1 << (accw - 1)) - 1) : -(1 << (accw - 1));
            continue;
`endif
         end
         s = s & ((1 << fw) - 1);
         if (s > hi) s = s - (1 << fw);
         a = s * (1 << k);
      end
      res = a;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_job(input int len, input int n, input int e0, input int v0,
                         input int e1, input int v1, input bit gaps, input string nm);
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            cfg_len  = 8'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = 8'(beats[i]);
         cfg_len  = (i == 0) ? 8'(len) : 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk({nm, " out_valid0"}, int'(out_valid0), 1);
      chk({nm, " in_ready0"}, int'(in_ready0), 0);
      chk({nm, " out_data0"}, int'(out_data0), e0);
      chk({nm, " ovf0"}, int'(ovf0), v0);
      chk({nm, " out_valid1"}, int'(out_valid1), 1);
      chk({nm, " out_data1"}, int'(out_data1), e1);
      chk({nm, " ovf1"}, int'(ovf1), v1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " drop out_valid0"}, int'(out_valid0), 0);
      chk({nm, " idle in_ready0"}, int'(in_ready0), 1);
      chk({nm, " keep out_data0"}, int'(out_data0), e0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r0, o0, r1, o1, len, n;

      tbl[0] = mk(3, 3, 5, 3, -7, 0, 0, -4, 0, -4, 0);
      tbl[1] = mk(0, 1, 127, 0, 0, 0, 0, 124, 0, 124, 0);
`ifdef ACC_SAT_EN
      tbl[2] = mk(5, 5, 127, 127, 127, 127, 127, 620, 0, 511, 1);
      tbl[3] = mk(5, 5, -128, -128, -128, -128, -128, -640, 0, -512, 1);
`else
      tbl[2] = mk(5, 5, 127, 127, 127, 127, 127, 620, 0, -404, 1);
      tbl[3] = mk(5, 5, -128, -128, -128, -128, -128, -640, 0, 384, 1);
`endif
      tbl[4] = mk(2, 2, -128, -128, 0, 0, 0, -256, 0, -256, 0);
      tbl[5] = mk(4, 4, 4, -4, 100, -1, 0, 96, 0, 96, 0);
      tbl[6] = mk(3, 3, 1, 2, 3, 0, 0, 0, 0, 0, 0);

      // Reset values while rst_n is held low, before any clock edge.
      #2;
      chk("rst out_valid", int'(out_valid0), 0);
      chk("rst out_data", int'(out_data0), 0);
      chk("rst in_ready", int'(in_ready0), 1);
      chk("rst ovf", int'(ovf0), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < 5; j++) beats[j] = int'($signed(tbl[i].b[j]));
         do_job(int'(tbl[i].len), int'(tbl[i].n), int'(tbl[i].d0), int'(tbl[i].o0),
                int'(tbl[i].d1), int'(tbl[i].o1), 1'b0, $sformatf("vec%0d", i));
      end

      // Backpressure: result held, beats refused while out_ready is low.
      beats[0] = 5; beats[1] = 3; beats[2] = -7;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'(beats[i]); cfg_len = 8'd3;
         @(posedge clk); #1;
      end
      in_data = 8'sd99;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp out_valid", int'(out_valid0), 1);
         chk("bp out_data", int'(out_data0), -4);
         chk("bp in_ready", int'(in_ready0), 0);
      end
      in_data = 8'sd16; cfg_len = 8'd1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp release out_valid", int'(out_valid0), 0);
      chk("bp release out_data", int'(out_data0), -4);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp next job out_valid", int'(out_valid0), 1);
      chk("bp next job out_data", int'(out_data0), 16);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Clear after two of four beats; the partial job must be discarded.
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 8'sd5; cfg_len = 8'd4;
         @(posedge clk); #1;
      end
      clear = 1'b1; in_data = 8'sd7;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      chk("clr out_valid", int'(out_valid0), 0);
      chk("clr in_ready", int'(in_ready0), 1);
      beats[0] = 8;
      do_job(1, 1, 8, 0, 8, 0, 1'b0, "clr next");

      // Clear while holding a result.
      in_valid = 1'b1; in_data = 8'sd20; cfg_len = 8'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("clr hold pre", int'(out_valid0), 1);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clr hold out_valid", int'(out_valid0), 0);
      chk("clr hold in_ready", int'(in_ready0), 1);

      // Asynchronous reset mid-cycle while holding an overflowed result.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'sd127; cfg_len = 8'd5;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("ar pre out_valid", int'(out_valid0), 1);
      chk("ar pre ovf1", int'(ovf1), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar out_valid", int'(out_valid0), 0);
      chk("ar out_data", int'(out_data0), 0);
      chk("ar in_ready", int'(in_ready0), 1);
      chk("ar out_data1", int'(out_data1), 0);
      chk("ar ovf1", int'(ovf1), 0);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ar after out_valid", int'(out_valid0), 0);

      // Randomized jobs against the reference model.
      for (int r = 0; r < 40; r++) begin
         len = $urandom_range(0, 8);
         n   = (len == 0) ? 1 : len;
         for (int j = 0; j < n; j++) beats[j] = int'($urandom_range(0, 255)) - 128;
         model(16, n, r0, o0);
         model(10, n, r1, o1);
         do_job(len, n, r0, o0, r1, o1, 1'b1, $sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
